// File: rtl/adc_seqctl.sv
// SAR ADC conversion sequencer: drives init/sample/compare/update phases
// and collects the serial comparator decisions into a parallel result word.
module adc_seqctl #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [4:0]       cfg_ncomp,
  input  logic [LEN_W-1:0] cfg_samp_len,
  input  logic [LEN_W-1:0] cfg_comp_len,
  input  logic             comp_out,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_comp,
  output logic             seq_update,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  localparam int unsigned CNT_W = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SAMP,
    S_COMP,
    S_UPDATE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   n_lat, n_eff;
  logic [LEN_W-1:0]   s_lat, s_eff;
  logic [LEN_W-1:0]   c_lat, c_eff;
  logic [LEN_W-1:0]   ph_cnt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_inc;
  logic [NBITS-1:0]   shreg;
  logic               samp_last, comp_last, last_bit;
  logic               seq_init_d, seq_samp_d, seq_comp_d, seq_update_d;
  logic               busy_d, done_d;

  // Normalise configuration: zero lengths become 1, ncomp is clipped to 1..NBITS
  always_comb begin
    n_eff = CNT_W'(cfg_ncomp);
    if (cfg_ncomp == '0)
      n_eff = CNT_W'(1);
    else if (32'(cfg_ncomp) > NBITS)
      n_eff = CNT_W'(NBITS);
    s_eff = (cfg_samp_len == '0) ? LEN_W'(1) : cfg_samp_len;
    c_eff = (cfg_comp_len == '0) ? LEN_W'(1) : cfg_comp_len;
  end

  assign samp_last   = (ph_cnt == s_lat - LEN_W'(1));
  assign comp_last   = (ph_cnt == c_lat - LEN_W'(1));
  assign bit_cnt_inc = bit_cnt + CNT_W'(1);
  assign last_bit    = (bit_cnt_inc >= n_lat);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_b)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_INIT;
      S_INIT:   state_nxt = S_SAMP;
      S_SAMP:   if (samp_last) state_nxt = S_COMP;
      S_COMP:   if (comp_last) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = last_bit ? S_IDLE : S_COMP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    seq_init_d   = (state_nxt == S_INIT);
    seq_samp_d   = (state_nxt == S_SAMP);
    seq_comp_d   = (state_nxt == S_COMP);
    seq_update_d = (state_nxt == S_UPDATE);
    busy_d       = (state_nxt != S_IDLE);
    done_d       = (state == S_UPDATE) && (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      seq_init   <= 1'b0;
      seq_samp   <= 1'b0;
      seq_comp   <= 1'b0;
      seq_update <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      seq_init   <= seq_init_d;
      seq_samp   <= seq_samp_d;
      seq_comp   <= seq_comp_d;
      seq_update <= seq_update_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Datapath: config latch, phase/bit counters, decision shift register
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      n_lat   <= '0;
      s_lat   <= '0;
      c_lat   <= '0;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_lat   <= n_eff;
            s_lat   <= s_eff;
            c_lat   <= c_eff;
            ph_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        S_INIT: ph_cnt <= '0;
        S_SAMP: ph_cnt <= samp_last ? '0 : ph_cnt + LEN_W'(1);
        S_COMP: begin
          if (comp_last) begin
            ph_cnt <= '0;
            shreg  <= {shreg[NBITS-2:0], comp_out};
          end else begin
            ph_cnt <= ph_cnt + LEN_W'(1);
          end
        end
        S_UPDATE: begin
          bit_cnt <= bit_cnt_inc;
          if (last_bit)
            result <= shreg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_seqctl.sv
// Randomised self-checking bench for adc_seqctl; expected phase trace and
// result come from a queue-based model of the conversion schedule.
module tb_adc_seqctl;

  localparam int NBITS = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             start = 1'b0;
  logic [4:0]       cfg_ncomp = '0;
  logic [LEN_W-1:0] cfg_samp_len = '0;
  logic [LEN_W-1:0] cfg_comp_len = '0;
  logic             comp_out = 1'b0;
  logic             seq_init, seq_samp, seq_comp, seq_update;
  logic             busy, done;
  logic [NBITS-1:0] result;

  int errors = 0;
  int checks = 0;
  logic [NBITS-1:0] exp_result = '0;

  adc_seqctl #(.NBITS(NBITS), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start),
    .cfg_ncomp    (cfg_ncomp),
    .cfg_samp_len (cfg_samp_len),
    .cfg_comp_len (cfg_comp_len),
    .comp_out     (comp_out),
    .seq_init     (seq_init),
    .seq_samp     (seq_samp),
    .seq_comp     (seq_comp),
    .seq_update   (seq_update),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  // Checks one idle cycle at the current negedge, then advances a cycle
  task automatic idle_cycles(input string name, input int ncyc);
    for (int unsigned i = 0; i < ncyc; i++) begin
      checks++;
      if ({seq_init, seq_samp, seq_comp, seq_update} !== 4'b0000) begin
        errors++;
        $display("FAIL %s_seq idle%0d: got %b want 0000", name, i,
                 {seq_init, seq_samp, seq_comp, seq_update});
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy idle%0d: got %b want 0", name, i, busy);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s_done idle%0d: got %b want 0", name, i, done);
      end
      checks++;
      if (result !== exp_result) begin
        errors++;
        $display("FAIL %s_result idle%0d: got %h want %h", name, i, result, exp_result);
      end
      @(negedge clk);
    end
  endtask

  // One conversion. mode: 0 random comp_out, 1 toggle every cycle, 2 decisions from vec (MSB first).
  // hold keeps start high while busy; abort_at>0 asserts reset during that cycle.
  task automatic run_conv(input string name, input int ncfg, input int scfg, input int ccfg,
                          input int mode, input logic [15:0] vec, input bit hold,
                          input int abort_at);
    int n, s, c, nd;
    int ph[$];
    logic [NBITS-1:0] acc;
    logic [3:0] ev, av;
    n = (ncfg == 0) ? 1 : ((ncfg > NBITS) ? NBITS : ncfg);
    s = (scfg == 0) ? 1 : scfg;
    c = (ccfg == 0) ? 1 : ccfg;
    ph.push_back(1);
    repeat (s) ph.push_back(2);
    repeat (n) begin
      repeat (c) ph.push_back(3);
      ph.push_back(4);
    end
    cfg_ncomp    = 5'(ncfg);
    cfg_samp_len = 8'(scfg);
    cfg_comp_len = 8'(ccfg);
    start = 1'b1;
    acc = '0;
    nd = 0;
    if (mode == 2) comp_out = vec[n-1];
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= ph.size(); k++) begin
      ev = (ph[k-1] == 1) ? 4'b1000 : (ph[k-1] == 2) ? 4'b0100 :
           (ph[k-1] == 3) ? 4'b0010 : 4'b0001;
      av = {seq_init, seq_samp, seq_comp, seq_update};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL %s_phase cyc%0d: got %b want %b", name, k, av, ev);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy cyc%0d: got %b want 1", name, k, busy);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s_done cyc%0d: got %b want 0", name, k, done);
      end
      checks++;
      if (result !== exp_result) begin
        errors++;
        $display("FAIL %s_hold cyc%0d: got %h want %h", name, k, result, exp_result);
      end
      if (k == abort_at) begin
        rst_b = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        exp_result = '0;
        idle_cycles({name, "_abort"}, 2);
        return;
      end
      case (mode)
        0: comp_out = 1'($urandom);
        1: comp_out = ~comp_out;
        default: comp_out = (nd < n) ? vec[n-1-nd] : 1'b0;
      endcase
      if (ph[k-1] == 3 && k < ph.size() && ph[k] == 4) begin
        acc = {acc[NBITS-2:0], comp_out};
        nd++;
      end
      start        = hold ? 1'b1 : ($urandom_range(0, 3) == 0);
      cfg_ncomp    = 5'($urandom);
      cfg_samp_len = 8'($urandom);
      cfg_comp_len = 8'($urandom);
      @(negedge clk);
    end
    exp_result = acc;
    checks++;
    if ({seq_init, seq_samp, seq_comp, seq_update} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_end_seq: got %b want 0000", name,
               {seq_init, seq_samp, seq_comp, seq_update});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_busy: got %b want 0", name, busy);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got %b want 1", name, done);
    end
    checks++;
    if (result !== exp_result) begin
      errors++;
      $display("FAIL %s_result: got %h want %h", name, result, exp_result);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    start = 1'b1;
    cfg_ncomp = 5'd4;
    cfg_samp_len = 8'd2;
    cfg_comp_len = 8'd1;
    @(negedge clk);
    @(negedge clk);
    exp_result = '0;
    idle_cycles("reset", 1);
    rst_b = 1'b1;
    start = 1'b0;
    idle_cycles("release", 3);
  endtask

  task automatic test_basic();
    run_conv("basic", 4, 2, 1, 2, 16'h000B, 1'b0, 0);
    checks++;
    if (result !== 16'h000B) begin
      errors++;
      $display("FAIL basic_word: got %h want 000b", result);
    end
    @(negedge clk);
    idle_cycles("basic_after", 2);
  endtask

  task automatic test_clip();
    run_conv("clip", 31, 0, 0, 2, 16'hAAAA, 1'b0, 0);
    checks++;
    if (result !== 16'hAAAA) begin
      errors++;
      $display("FAIL clip_word: got %h want aaaa", result);
    end
    @(negedge clk);
    idle_cycles("clip_after", 1);
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 8; i++) begin
      run_conv("rand", int'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), 0, 16'h0, 1'b0, 0);
      @(negedge clk);
      idle_cycles("rand_gap", int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_back_to_back();
    run_conv("b2b_a", 3, 1, 2, 0, 16'h0, 1'b1, 0);
    run_conv("b2b_b", 5, 2, 1, 0, 16'h0, 1'b1, 0);
    run_conv("b2b_c", 2, 3, 1, 0, 16'h0, 1'b0, 0);
    @(negedge clk);
    idle_cycles("b2b_after", 2);
  endtask

  task automatic test_mid_reset();
    // N=8, S=2, C=2: third COMP phase starts in cycle 10
    run_conv("midrst", 8, 2, 2, 0, 16'h0, 1'b0, 10);
    run_conv("midrst_clean", 6, 1, 1, 0, 16'h0, 1'b0, 0);
    @(negedge clk);
    idle_cycles("midrst_after", 1);
  endtask

  task automatic test_sampling();
    run_conv("sample16", 16, 1, 3, 1, 16'h0, 1'b0, 0);
    @(negedge clk);
    run_conv("sample7", 7, 2, 3, 1, 16'h0, 1'b0, 0);
    @(negedge clk);
    idle_cycles("sample_after", 1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_clip();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_sampling();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
